// File: rtl/fifo_byte_serializer_if.sv
// Read port toward the byte FIFO plus the serial-line status outputs of fifo_byte_serializer.
// master = serializer side, slave = FIFO/board side.
interface fifo_byte_serializer_if #(
  parameter int CNT_W = 8
);
  logic             en;
  logic             fifo_ren;
  logic [7:0]       fifo_dout;
  logic             fifo_error;
  logic             tx;
  logic             busy;
  logic             tx_done;
  logic [CNT_W-1:0] frame_cnt;

  modport master (
    input  en, fifo_dout, fifo_error,
    output fifo_ren, tx, busy, tx_done, frame_cnt
  );

  modport slave (
    output en, fifo_dout, fifo_error,
    input  fifo_ren, tx, busy, tx_done, frame_cnt
  );
endinterface

// File: rtl/fifo_byte_serializer.sv
// Drains a byte FIFO through its ren/dout/error read port and sends each byte as an
// LSB-first async serial frame. Define SERIALIZER_PARITY_EN to add an even parity bit.
module fifo_byte_serializer #(
  parameter int DIV   = 4,
  parameter int CNT_W = 8
) (
  input logic                    clk,
  input logic                    rst,
  fifo_byte_serializer_if.master bus
);
  localparam int                BAUD_W    = $clog2(DIV);
  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(DIV - 1);
  localparam logic [BAUD_W-1:0] BAUD_PRE  = BAUD_W'(DIV - 2);

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    WAIT,
    START,
    DATA,
    PARITY,
    STOP
  } state_t;

  state_t            state_reg;
  logic [7:0]        shift_reg;
  logic [BAUD_W-1:0] baud_reg;
  logic [2:0]        bit_reg;
  logic              ren_reg;
  logic              tx_reg;
  logic              busy_reg;
  logic              done_reg;
  logic [CNT_W-1:0]  cnt_reg;
`ifdef SERIALIZER_PARITY_EN
  logic              parity_reg;
`endif

  // Every output comes straight from a register; nothing combinational from the inputs.
  assign bus.fifo_ren  = ren_reg;
  assign bus.tx        = tx_reg;
  assign bus.busy      = busy_reg;
  assign bus.tx_done   = done_reg;
  assign bus.frame_cnt = cnt_reg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg  <= IDLE;
      shift_reg  <= '0;
      baud_reg   <= '0;
      bit_reg    <= '0;
      ren_reg    <= 1'b0;
      tx_reg     <= 1'b1;
      busy_reg   <= 1'b0;
      done_reg   <= 1'b0;
      cnt_reg    <= '0;
`ifdef SERIALIZER_PARITY_EN
      parity_reg <= 1'b0;
`endif
    end else begin
      ren_reg  <= 1'b0;
      done_reg <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (bus.en) begin
            state_reg <= FETCH;
            ren_reg   <= 1'b1;
          end
        end

        FETCH: begin
          state_reg <= WAIT;
        end

        WAIT: begin
          // An error here means the FIFO was empty; the byte is dropped and we retry.
          if (bus.fifo_error) begin
            state_reg <= IDLE;
          end else begin
            shift_reg  <= bus.fifo_dout;
`ifdef SERIALIZER_PARITY_EN
            parity_reg <= ^bus.fifo_dout;
`endif
            state_reg  <= START;
            tx_reg     <= 1'b0;
            busy_reg   <= 1'b1;
            baud_reg   <= '0;
          end
        end

        START: begin
          if (baud_reg == BAUD_LAST) begin
            baud_reg  <= '0;
            bit_reg   <= '0;
            state_reg <= DATA;
            tx_reg    <= shift_reg[0];
          end else begin
            baud_reg <= baud_reg + 1'b1;
          end
        end

        DATA: begin
          if (baud_reg == BAUD_LAST) begin
            baud_reg <= '0;
            if (bit_reg == 3'd7) begin
`ifdef SERIALIZER_PARITY_EN
              state_reg <= PARITY;
              tx_reg    <= parity_reg;
`else
              state_reg <= STOP;
              tx_reg    <= 1'b1;
`endif
            end else begin
              bit_reg   <= bit_reg + 1'b1;
              shift_reg <= shift_reg >> 1;
              tx_reg    <= shift_reg[1];
            end
          end else begin
            baud_reg <= baud_reg + 1'b1;
          end
        end

`ifdef SERIALIZER_PARITY_EN
        PARITY: begin
          if (baud_reg == BAUD_LAST) begin
            baud_reg  <= '0;
            state_reg <= STOP;
            tx_reg    <= 1'b1;
          end else begin
            baud_reg <= baud_reg + 1'b1;
          end
        end
`endif

        STOP: begin
          // Raised one edge early so the pulse and the new count land on the last stop clock.
          if (baud_reg == BAUD_PRE) begin
            done_reg <= 1'b1;
            cnt_reg  <= cnt_reg + CNT_W'(1);
          end
          if (baud_reg == BAUD_LAST) begin
            baud_reg <= '0;
            busy_reg <= 1'b0;
            if (bus.en) begin
              state_reg <= FETCH;
              ren_reg   <= 1'b1;
            end else begin
              state_reg <= IDLE;
            end
          end else begin
            baud_reg <= baud_reg + 1'b1;
          end
        end

        default: begin
          state_reg <= IDLE;
          tx_reg    <= 1'b1;
          busy_reg  <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_fifo_byte_serializer.sv
// Bench for fifo_byte_serializer: behavioural FIFO, a tx/busy frame recorder and
// spec-derived expected waveforms; one task per scenario.
`timescale 1ns/1ps
module tb_fifo_byte_serializer;
  localparam int DIV   = 4;
  localparam int CNT_W = 8;
`ifdef SERIALIZER_PARITY_EN
  localparam int FRAME_CLKS = 11 * DIV;
  localparam bit PAR        = 1'b1;
`else
  localparam int FRAME_CLKS = 10 * DIV;
  localparam bit PAR        = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  fifo_byte_serializer_if #(.CNT_W(CNT_W)) sif();

  fifo_byte_serializer #(.DIV(DIV), .CNT_W(CNT_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (sif)
  );

  int checks   = 0;
  int failures = 0;
  int exp_cnt  = 0;

  // Behavioural FIFO: 1-cycle read latency, error on empty read, garbage otherwise.
  logic [7:0] fifo_q[$];
  int         pops = 0;
  always @(posedge clk) begin
    if (sif.fifo_ren) begin
      pops++;
      if (fifo_q.size() == 0) begin
        sif.fifo_error <= 1'b1;
        sif.fifo_dout  <= 8'($urandom);
      end else begin
        sif.fifo_error <= 1'b0;
        sif.fifo_dout  <= fifo_q.pop_front();
      end
    end else begin
      sif.fifo_error <= 1'($urandom_range(0, 1));
      sif.fifo_dout  <= 8'($urandom);
    end
  end

  // Recorder: cycle stamps of ren/tx_done and the tx samples of every busy window.
  int          cyc = 0;
  int          ren_cyc[$];
  int          done_cyc[$];
  logic [63:0] frame_wave[$];
  int          frame_len[$];
  int          frame_start[$];
  bit          in_frame = 1'b0;
  logic [63:0] cap;
  int          cap_len;
  int          cap_start;
  int          idle_low = 0;

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    if (sif.fifo_ren) ren_cyc.push_back(cyc);
    if (sif.tx_done) done_cyc.push_back(cyc);
    if (!sif.busy && !sif.tx) idle_low++;
    if (sif.busy) begin
      if (!in_frame) begin
        in_frame  = 1'b1;
        cap       = '0;
        cap_len   = 0;
        cap_start = cyc;
      end
      if (cap_len < 64) cap[cap_len] = sif.tx;
      cap_len++;
    end else if (in_frame) begin
      in_frame = 1'b0;
      frame_wave.push_back(cap);
      frame_len.push_back(cap_len);
      frame_start.push_back(cap_start);
    end
  end

  // Expected tx per clock: start 0, data LSB first, optional even parity, stop 1.
  function automatic logic [63:0] exp_wave(input logic [7:0] b);
    logic [63:0] w;
    int          s;
    w = '0;
    for (int i = 0; i < FRAME_CLKS; i++) begin
      s = i / DIV;
      if (s == 0)              w[i] = 1'b0;
      else if (s <= 8)         w[i] = b[s-1];
      else if (PAR && s == 9)  w[i] = ^b;
      else                     w[i] = 1'b1;
    end
    return w;
  endfunction

  task automatic step(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      #1;
    end
  endtask

  task automatic clear_logs();
    ren_cyc.delete();
    done_cyc.delete();
    frame_wave.delete();
    frame_len.delete();
    frame_start.delete();
    idle_low = 0;
  endtask

  task automatic wait_frames(input int n, input int bound, output bit ok);
    int k = 0;
    while (frame_wave.size() < n && k < bound) begin
      step();
      k++;
    end
    ok = (frame_wave.size() >= n);
  endtask

  task automatic wait_busy(input int bound, output bit ok);
    int k = 0;
    while (!in_frame && k < bound) begin
      step();
      k++;
    end
    ok = in_frame;
  endtask

  task automatic test_reset();
    rst    = 1'b1;
    sif.en = 1'b0;
    step(3);
    checks += 6;
    if (sif.tx !== 1'b1) begin failures++; $display("FAIL reset_tx: got %b expected 1", sif.tx); end
    if (sif.fifo_ren !== 1'b0) begin failures++; $display("FAIL reset_ren: got %b expected 0", sif.fifo_ren); end
    if (sif.busy !== 1'b0) begin failures++; $display("FAIL reset_busy: got %b expected 0", sif.busy); end
    if (sif.tx_done !== 1'b0) begin failures++; $display("FAIL reset_done: got %b expected 0", sif.tx_done); end
    if (sif.frame_cnt !== '0) begin failures++; $display("FAIL reset_cnt: got %0d expected 0", sif.frame_cnt); end
    if (pops !== 0) begin failures++; $display("FAIL reset_fifo_touched: got %0d reads expected 0", pops); end
    rst = 1'b0;
    step(2);
  endtask

  task automatic test_empty_retry();
    int cyc_at;
    int bad_gap = 0;
    clear_logs();
    cyc_at = cyc;
    sif.en = 1'b1;
    step(30);
    sif.en = 1'b0;
    step(4);
    checks++;
    if (ren_cyc.size() < 9) begin
      failures++; $display("FAIL empty_ren_count: got %0d expected >=9", ren_cyc.size());
    end
    checks++;
    if (ren_cyc.size() > 0 && ren_cyc[0] < cyc_at + 1) begin
      failures++; $display("FAIL empty_first_ren: got cycle %0d expected >= %0d", ren_cyc[0], cyc_at + 1);
    end
    for (int i = 1; i < ren_cyc.size(); i++)
      if (ren_cyc[i] - ren_cyc[i-1] != 3) bad_gap++;
    checks++;
    if (bad_gap != 0) begin failures++; $display("FAIL empty_retry_period: got %0d gaps not 3 expected 0", bad_gap); end
    checks += 3;
    if (idle_low != 0) begin failures++; $display("FAIL empty_tx_idle: got %0d low clocks expected 0", idle_low); end
    if (frame_wave.size() != 0) begin failures++; $display("FAIL empty_frames: got %0d expected 0", frame_wave.size()); end
    if (sif.frame_cnt !== CNT_W'(exp_cnt)) begin failures++; $display("FAIL empty_cnt: got %0d expected %0d", sif.frame_cnt, exp_cnt); end
  endtask

  task automatic test_single_55();
    bit ok;
    int end_cyc;
    int after = 0;
    sif.en = 1'b0;
    step(4);
    fifo_q.push_back(8'h55);
    clear_logs();
    sif.en = 1'b1;
    wait_frames(1, 200, ok);
    step(8);
    sif.en = 1'b0;
    step(4);
    exp_cnt++;
    checks++;
    if (!ok) begin
      failures++; $display("FAIL single_timeout: got %0d frames expected 1", frame_wave.size());
      return;
    end
    $display("frame byte=55 start=%0d len=%0d", frame_start[0], frame_len[0]);
    end_cyc = frame_start[0] + FRAME_CLKS - 1;
    checks += 5;
    if (frame_wave[0] !== exp_wave(8'h55)) begin failures++; $display("FAIL single_wave: got %h expected %h", frame_wave[0], exp_wave(8'h55)); end
    if (frame_len[0] != FRAME_CLKS) begin failures++; $display("FAIL single_len: got %0d expected %0d", frame_len[0], FRAME_CLKS); end
    if (done_cyc.size() != 1 || done_cyc[0] != end_cyc) begin
      failures++; $display("FAIL single_done: got %0d pulses first at %0d expected 1 at %0d",
                           done_cyc.size(), (done_cyc.size() > 0) ? done_cyc[0] : -1, end_cyc);
    end
    if (sif.frame_cnt !== CNT_W'(exp_cnt)) begin failures++; $display("FAIL single_cnt: got %0d expected %0d", sif.frame_cnt, exp_cnt); end
    if (ren_cyc.size() == 0 || ren_cyc[0] + 2 != frame_start[0]) begin
      failures++; $display("FAIL single_fetch_latency: got ren at %0d expected %0d", (ren_cyc.size() > 0) ? ren_cyc[0] : -1, frame_start[0] - 2);
    end
    foreach (ren_cyc[i]) if (ren_cyc[i] > end_cyc) after++;
    checks++;
    if (after < 2) begin failures++; $display("FAIL single_retry_resume: got %0d reads after frame expected >=2", after); end
  endtask

  task automatic test_back_to_back();
    bit ok;
    int last_end;
    int after = 0;
    sif.en = 1'b0;
    step(4);
    for (int i = 1; i <= 8; i++) fifo_q.push_back(8'(i));
    clear_logs();
    sif.en = 1'b1;
    wait_frames(8, 8 * (FRAME_CLKS + 10), ok);
    step(10);
    sif.en = 1'b0;
    step(4);
    exp_cnt += 8;
    checks++;
    if (!ok) begin
      failures++; $display("FAIL b2b_timeout: got %0d frames expected 8", frame_wave.size());
      return;
    end
    for (int i = 0; i < 8; i++) begin
      $display("frame byte=%02h start=%0d len=%0d", i + 1, frame_start[i], frame_len[i]);
      checks++;
      if (frame_wave[i] !== exp_wave(8'(i + 1))) begin
        failures++; $display("FAIL b2b_wave%0d: got %h expected %h", i, frame_wave[i], exp_wave(8'(i + 1)));
      end
      if (i > 0) begin
        checks++;
        if (frame_start[i] - frame_start[i-1] != FRAME_CLKS + 2) begin
          failures++; $display("FAIL b2b_gap%0d: got %0d expected %0d", i, frame_start[i] - frame_start[i-1], FRAME_CLKS + 2);
        end
      end
    end
    last_end = frame_start[7] + FRAME_CLKS - 1;
    foreach (ren_cyc[i]) if (ren_cyc[i] > last_end) after++;
    checks += 4;
    if (sif.frame_cnt !== CNT_W'(exp_cnt)) begin failures++; $display("FAIL b2b_cnt: got %0d expected %0d", sif.frame_cnt, exp_cnt); end
    if (done_cyc.size() != 8) begin failures++; $display("FAIL b2b_done: got %0d expected 8", done_cyc.size()); end
    if (after < 1) begin failures++; $display("FAIL b2b_ninth_read: got %0d reads expected >=1", after); end
    if (frame_wave.size() != 8) begin failures++; $display("FAIL b2b_extra_frame: got %0d expected 8", frame_wave.size()); end
  endtask

  task automatic test_en_drop();
    bit ok;
    int start;
    int late = 0;
    int k = 0;
    sif.en = 1'b0;
    step(4);
    fifo_q.push_back(8'hA5);
    clear_logs();
    sif.en = 1'b1;
    wait_busy(50, ok);
    checks++;
    if (!ok) begin failures++; $display("FAIL drop_no_start: got busy=%b expected 1", sif.busy); sif.en = 1'b0; return; end
    start = cap_start;
    while (cyc < start + 3 * DIV + 1 && k < 100) begin step(); k++; end
    sif.en = 1'b0;
    wait_frames(1, 100, ok);
    step(15);
    exp_cnt++;
    checks++;
    if (!ok) begin failures++; $display("FAIL drop_timeout: got %0d frames expected 1", frame_wave.size()); return; end
    $display("frame byte=a5 start=%0d len=%0d", frame_start[0], frame_len[0]);
    foreach (ren_cyc[i]) if (ren_cyc[i] > start) late++;
    checks += 5;
    if (frame_wave[0] !== exp_wave(8'hA5)) begin failures++; $display("FAIL drop_wave: got %h expected %h", frame_wave[0], exp_wave(8'hA5)); end
    if (late != 0) begin failures++; $display("FAIL drop_extra_ren: got %0d expected 0", late); end
    if (sif.busy !== 1'b0 || sif.tx !== 1'b1) begin failures++; $display("FAIL drop_idle: got busy=%b tx=%b expected 0 1", sif.busy, sif.tx); end
    if (frame_wave.size() != 1) begin failures++; $display("FAIL drop_frames: got %0d expected 1", frame_wave.size()); end
    if (sif.frame_cnt !== CNT_W'(exp_cnt)) begin failures++; $display("FAIL drop_cnt: got %0d expected %0d", sif.frame_cnt, exp_cnt); end
  endtask

  task automatic test_random_bytes();
    bit         ok;
    int         n;
    logic [7:0] sent[$];
    logic [7:0] b;
    sif.en = 1'b0;
    step(4);
    n = $urandom_range(3, 8);
    for (int i = 0; i < n; i++) begin
      b = 8'($urandom);
      sent.push_back(b);
      fifo_q.push_back(b);
    end
    clear_logs();
    sif.en = 1'b1;
    wait_frames(n, n * (FRAME_CLKS + 10), ok);
    sif.en = 1'b0;
    step(6);
    exp_cnt += n;
    checks++;
    if (!ok) begin failures++; $display("FAIL rand_timeout: got %0d frames expected %0d", frame_wave.size(), n); return; end
    for (int i = 0; i < n; i++) begin
      $display("frame byte=%02h start=%0d len=%0d", sent[i], frame_start[i], frame_len[i]);
      checks++;
      if (frame_wave[i] !== exp_wave(sent[i]) || frame_len[i] != FRAME_CLKS) begin
        failures++; $display("FAIL rand_wave%0d: got %h/%0d expected %h/%0d", i, frame_wave[i], frame_len[i], exp_wave(sent[i]), FRAME_CLKS);
      end
    end
    checks++;
    if (sif.frame_cnt !== CNT_W'(exp_cnt)) begin failures++; $display("FAIL rand_cnt: got %0d expected %0d", sif.frame_cnt, exp_cnt); end
  endtask

  task automatic test_reset_mid_frame();
    bit ok;
    int k = 0;
    sif.en = 1'b0;
    step(4);
    fifo_q.push_back(8'($urandom));
    clear_logs();
    sif.en = 1'b1;
    wait_busy(50, ok);
    checks++;
    if (!ok) begin failures++; $display("FAIL rstmid_no_start: got busy=%b expected 1", sif.busy); sif.en = 1'b0; return; end
    while (cyc < cap_start + 4 * DIV + 1 && k < 100) begin step(); k++; end
    rst = 1'b1;
    #1;
    exp_cnt = 0;
    checks += 3;
    if (sif.tx !== 1'b1) begin failures++; $display("FAIL rstmid_tx: got %b expected 1", sif.tx); end
    if (sif.busy !== 1'b0) begin failures++; $display("FAIL rstmid_busy: got %b expected 0", sif.busy); end
    if (sif.frame_cnt !== '0) begin failures++; $display("FAIL rstmid_cnt: got %0d expected 0", sif.frame_cnt); end
    step(2);
    clear_logs();
    rst = 1'b0;
    step();
    checks++;
    if (sif.fifo_ren !== 1'b1) begin failures++; $display("FAIL rstmid_fetch: got ren=%b expected 1", sif.fifo_ren); end
    step(10);
    sif.en = 1'b0;
    step(4);
    checks++;
    if (frame_wave.size() != 0) begin failures++; $display("FAIL rstmid_lost_byte: got %0d frames expected 0", frame_wave.size()); end
  endtask

`ifdef SERIALIZER_PARITY_EN
  task automatic test_parity();
    bit ok;
    sif.en = 1'b0;
    step(4);
    fifo_q.push_back(8'h07);
    clear_logs();
    sif.en = 1'b1;
    wait_frames(1, 200, ok);
    sif.en = 1'b0;
    step(6);
    exp_cnt++;
    checks++;
    if (!ok) begin failures++; $display("FAIL parity_timeout: got %0d frames expected 1", frame_wave.size()); return; end
    $display("frame byte=07 start=%0d len=%0d", frame_start[0], frame_len[0]);
    checks += 4;
    if (frame_wave[0] !== exp_wave(8'h07)) begin failures++; $display("FAIL parity_wave: got %h expected %h", frame_wave[0], exp_wave(8'h07)); end
    if (frame_len[0] != 44) begin failures++; $display("FAIL parity_len: got %0d expected 44", frame_len[0]); end
    if (frame_wave[0][9*DIV+1] !== 1'b1) begin failures++; $display("FAIL parity_bit: got %b expected 1", frame_wave[0][9*DIV+1]); end
    if (sif.frame_cnt !== CNT_W'(exp_cnt)) begin failures++; $display("FAIL parity_cnt: got %0d expected %0d", sif.frame_cnt, exp_cnt); end
  endtask
`endif

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got no finish expected finish within 2ms");
    $fatal(1, "watchdog expired");
  end

  initial begin
    sif.en = 1'b0;
    test_reset();
    test_empty_retry();
    test_single_55();
    test_back_to_back();
    test_en_drop();
    test_random_bytes();
    test_reset_mid_frame();
`ifdef SERIALIZER_PARITY_EN
    test_parity();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
